// File: rtl/control_seq_pkg.sv
// ---------------------------------------------------------------------------
// control_seq_pkg
// Shared definitions for the decode-stage control unit and its consumers.
//   - OP_* opcode constants (6-bit base encoding, zero-extended by users
//     whose opcode field is wider).
//   - CTRL_* bit indices into the control word, so the ID/EX, EX/MEM and
//     MEM/WB registers all slice the word the same way.
//   - Sequencer state and opcode-class enums.
// ---------------------------------------------------------------------------
package control_seq_pkg;

  localparam int OP_BASE_W = 6;

  localparam logic [OP_BASE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_BASE_W-1:0] OP_JUMP  = 6'h02;
  localparam logic [OP_BASE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_BASE_W-1:0] OP_MUL   = 6'h1C;
  localparam logic [OP_BASE_W-1:0] OP_LDB   = 6'h20;
  localparam logic [OP_BASE_W-1:0] OP_LDW   = 6'h23;
  localparam logic [OP_BASE_W-1:0] OP_STB   = 6'h28;
  localparam logic [OP_BASE_W-1:0] OP_STW   = 6'h2B;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_JUMP     = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_BYTEWORD = 6;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MULOP    = 8;
  localparam int CTRL_W        = 9;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_WAIT
  } seq_state_e;

  typedef enum logic [1:0] {
    OPK_NORMAL,
    OPK_MUL,
    OPK_ILLEGAL
  } op_kind_e;

  // The multiply word is needed both by the decoder and by the sequencer
  // when it issues after the wait, when the opcode is no longer trusted.
  function automatic ctrl_word_t ctrl_mul_word();
    ctrl_word_t w;
    w = '0;
    w[CTRL_REGWRITE] = 1'b1;
    w[CTRL_ALUSRC]   = 1'b1;
    w[CTRL_MULOP]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational opcode-to-control-word map.
//   opcode : in  [OPCODE_W] decode-stage opcode
//   word   : out ctrl_word_t control bits for a known opcode, 0 otherwise
//   kind   : out op_kind_e   NORMAL, MUL (needs the sequencer) or ILLEGAL
// ---------------------------------------------------------------------------
module control_decode
  import control_seq_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          word,
  output op_kind_e            kind
);

  localparam logic [OPCODE_W-1:0] L_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] L_JUMP  = OPCODE_W'(OP_JUMP);
  localparam logic [OPCODE_W-1:0] L_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] L_MUL   = OPCODE_W'(OP_MUL);
  localparam logic [OPCODE_W-1:0] L_LDB   = OPCODE_W'(OP_LDB);
  localparam logic [OPCODE_W-1:0] L_LDW   = OPCODE_W'(OP_LDW);
  localparam logic [OPCODE_W-1:0] L_STB   = OPCODE_W'(OP_STB);
  localparam logic [OPCODE_W-1:0] L_STW   = OPCODE_W'(OP_STW);

  // Unknown opcodes fall through to an all-zero word so nothing downstream
  // ever sees X; the ILLEGAL kind lets the sequencer flag them.
  always_comb begin
    word = '0;
    kind = OPK_NORMAL;
    case (opcode)
      L_RTYPE: begin
        word[CTRL_REGWRITE] = 1'b1;
        word[CTRL_ALUSRC]   = 1'b1;
      end
      L_LDB: begin
        word[CTRL_REGWRITE] = 1'b1;
        word[CTRL_MEMTOREG] = 1'b1;
        word[CTRL_MEMREAD]  = 1'b1;
      end
      L_LDW: begin
        word[CTRL_REGWRITE] = 1'b1;
        word[CTRL_MEMTOREG] = 1'b1;
        word[CTRL_MEMREAD]  = 1'b1;
        word[CTRL_BYTEWORD] = 1'b1;
      end
      L_STB: begin
        word[CTRL_MEMWRITE] = 1'b1;
      end
      L_STW: begin
        word[CTRL_MEMWRITE] = 1'b1;
        word[CTRL_BYTEWORD] = 1'b1;
      end
      L_BEQ: begin
        word[CTRL_BRANCH] = 1'b1;
        word[CTRL_ALUSRC] = 1'b1;
      end
      L_JUMP: begin
        word[CTRL_JUMP] = 1'b1;
      end
      L_MUL: begin
        word = ctrl_mul_word();
        kind = OPK_MUL;
      end
      default: begin
        kind = OPK_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// ---------------------------------------------------------------------------
// control_seq
// Decode-stage control unit: registered control word, multi-cycle MUL
// sequencer, flush/stall handling and illegal-opcode detection.
//   clk, reset    : clock and synchronous active-high reset
//   stall         : emit a bubble, freeze the sequencer
//   flush         : emit a bubble, abort the sequencer
//   valid_in      : opcode is a real instruction
//   opcode        : decode-stage opcode
//   regwrite .. mulop : registered control bits
//   valid_out     : control word is a real instruction
//   busy          : sequencer occupied, upstream must hold the opcode
//   illegal       : one-cycle pulse on an unknown opcode
//   illegal_count : saturating count of unknown opcodes
// ---------------------------------------------------------------------------
module control_seq
  import control_seq_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                regwrite,
  output logic                memtoreg,
  output logic                branch,
  output logic                jump,
  output logic                memwrite,
  output logic                memread,
  output logic                byteword,
  output logic                alusrc,
  output logic                mulop,
  output logic                valid_out,
  output logic                busy,
  output logic                illegal,
  output logic [CNT_W-1:0]    illegal_count
);

  // The wait counter starts at MUL_LAT-2: one cycle is spent on accept and
  // the final count of zero is the issue cycle.
  localparam bit         MUL_SINGLE   = (MUL_LAT == 1);
  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LAT - 2);

  seq_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  ctrl_word_t       ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  ctrl_word_t dec_word;
  op_kind_e   dec_kind;

  control_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode (opcode),
    .word   (dec_word),
    .kind   (dec_kind)
  );

  // Next-state and next-output logic. Everything defaults to a bubble with
  // the sequencer holding; flush beats stall, stall beats decode. Busy is
  // simply "we will be in MUL_WAIT next cycle", which also holds under stall.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ctrl_d          = '0;
    valid_d         = 1'b0;
    illegal_d       = 1'b0;
    illegal_count_d = illegal_count_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            case (dec_kind)
              OPK_NORMAL: begin
                ctrl_d  = dec_word;
                valid_d = 1'b1;
              end
              OPK_MUL: begin
                if (MUL_SINGLE) begin
                  ctrl_d  = ctrl_mul_word();
                  valid_d = 1'b1;
                end else begin
                  state_d = ST_MUL_WAIT;
                  cnt_d   = MUL_CNT_INIT;
                end
              end
              default: begin
                illegal_d = 1'b1;
                if (illegal_count_q != {CNT_W{1'b1}}) begin
                  illegal_count_d = illegal_count_q + CNT_W'(1);
                end
              end
            endcase
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_q == 8'd0) begin
            ctrl_d  = ctrl_mul_word();
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_MUL_WAIT);
  end

  // State and output registers with synchronous reset; a reset mid-MUL
  // drops the operation without issuing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 8'd0;
      ctrl_q          <= '0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ctrl_q          <= ctrl_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign regwrite      = ctrl_q[CTRL_REGWRITE];
  assign memtoreg      = ctrl_q[CTRL_MEMTOREG];
  assign branch        = ctrl_q[CTRL_BRANCH];
  assign jump          = ctrl_q[CTRL_JUMP];
  assign memwrite      = ctrl_q[CTRL_MEMWRITE];
  assign memread       = ctrl_q[CTRL_MEMREAD];
  assign byteword      = ctrl_q[CTRL_BYTEWORD];
  assign alusrc        = ctrl_q[CTRL_ALUSRC];
  assign mulop         = ctrl_q[CTRL_MULOP];
  assign valid_out     = valid_q;
  assign busy          = busy_q;
  assign illegal       = illegal_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_control_seq.sv
// ---------------------------------------------------------------------------
// tb_control_seq
// Drives three control_seq instances with one shared input stream:
//   dut 0: MUL_LAT = 4, CNT_W = 8
//   dut 1: MUL_LAT = 1, CNT_W = 8
//   dut 2: MUL_LAT = 3, CNT_W = 2
// A reference model predicts each instance's outputs from the decode table
// and a "cycles left until the MUL issues" count.
// ---------------------------------------------------------------------------
module tb_control_seq;
  import control_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       flush;
  logic       valid_in;
  logic [5:0] opcode;

  logic [2:0] regwriteO, memtoregO, branchO, jumpO, memwriteO, memreadO;
  logic [2:0] bytewordO, alusrcO, mulopO, validO, busyO, illegalO;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;

  int nCompared;
  int nMismatched;

  logic [11:0] expOut [3];
  int          expCnt [3];
  int          remain [3];

  localparam logic [9:0] MULW = 10'b1000000111;

  control_seq #(.OPCODE_W(6), .MUL_LAT(4), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .opcode(opcode),
    .regwrite(regwriteO[0]), .memtoreg(memtoregO[0]), .branch(branchO[0]),
    .jump(jumpO[0]), .memwrite(memwriteO[0]), .memread(memreadO[0]),
    .byteword(bytewordO[0]), .alusrc(alusrcO[0]), .mulop(mulopO[0]),
    .valid_out(validO[0]), .busy(busyO[0]), .illegal(illegalO[0]),
    .illegal_count(cntA)
  );

  control_seq #(.OPCODE_W(6), .MUL_LAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .opcode(opcode),
    .regwrite(regwriteO[1]), .memtoreg(memtoregO[1]), .branch(branchO[1]),
    .jump(jumpO[1]), .memwrite(memwriteO[1]), .memread(memreadO[1]),
    .byteword(bytewordO[1]), .alusrc(alusrcO[1]), .mulop(mulopO[1]),
    .valid_out(validO[1]), .busy(busyO[1]), .illegal(illegalO[1]),
    .illegal_count(cntB)
  );

  control_seq #(.OPCODE_W(6), .MUL_LAT(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .opcode(opcode),
    .regwrite(regwriteO[2]), .memtoreg(memtoregO[2]), .branch(branchO[2]),
    .jump(jumpO[2]), .memwrite(memwriteO[2]), .memread(memreadO[2]),
    .byteword(bytewordO[2]), .alusrc(alusrcO[2]), .mulop(mulopO[2]),
    .valid_out(validO[2]), .busy(busyO[2]), .illegal(illegalO[2]),
    .illegal_count(cntC)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latOf(input int k);
    case (k)
      0: return 4;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cntMaxOf(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  // Expected word in the order {regwrite, memtoreg, branch, jump, memwrite,
  // memread, byteword, alusrc, mulop, valid_out}; kind 0 = plain, 1 = MUL,
  // 2 = unknown.
  task automatic decodeRef(input logic [5:0] op, output logic [9:0] w, output int kind);
    kind = 0;
    w    = '0;
    case (op)
      OP_RTYPE: w = 10'b1000000101;
      OP_LDB:   w = 10'b1100010001;
      OP_LDW:   w = 10'b1100011001;
      OP_STB:   w = 10'b0000100001;
      OP_STW:   w = 10'b0000101001;
      OP_BEQ:   w = 10'b0010000101;
      OP_JUMP:  w = 10'b0001000001;
      OP_MUL: begin w = MULW; kind = 1; end
      default:  kind = 2;
    endcase
  endtask

  task automatic modelStep(input logic r, input logic s, input logic f,
                           input logic v, input logic [5:0] op);
    logic [9:0] w;
    logic [9:0] outW;
    logic       bsy;
    logic       ill;
    int         kind;
    decodeRef(op, w, kind);
    for (int k = 0; k < 3; k++) begin
      outW = '0;
      bsy  = 1'b0;
      ill  = 1'b0;
      if (r) begin
        remain[k] = 0;
        expCnt[k] = 0;
      end else if (f) begin
        remain[k] = 0;
      end else if (s) begin
        bsy = (remain[k] > 0);
      end else if (remain[k] > 0) begin
        remain[k] = remain[k] - 1;
        if (remain[k] == 0) outW = MULW;
        else bsy = 1'b1;
      end else if (v) begin
        if (kind == 1) begin
          if (latOf(k) == 1) outW = MULW;
          else begin
            remain[k] = latOf(k) - 1;
            bsy = 1'b1;
          end
        end else if (kind == 0) begin
          outW = w;
        end else begin
          ill = 1'b1;
          if (expCnt[k] < cntMaxOf(k)) expCnt[k] = expCnt[k] + 1;
        end
      end
      expOut[k] = {outW, bsy, ill};
    end
  endtask

  // Compare every instance's outputs and counter against the model.
  task automatic checkOutput(input string tag);
    logic [11:0] obs;
    logic [7:0]  cntObs;
    for (int k = 0; k < 3; k++) begin
      obs = {regwriteO[k], memtoregO[k], branchO[k], jumpO[k], memwriteO[k],
             memreadO[k], bytewordO[k], alusrcO[k], mulopO[k], validO[k],
             busyO[k], illegalO[k]};
      case (k)
        0: cntObs = cntA;
        1: cntObs = cntB;
        default: cntObs = {6'b0, cntC};
      endcase
      nCompared++;
      assert (obs === expOut[k]) else begin
        nMismatched++;
        $error("[TB] FAIL %s dut%0d outputs observed=%b expected=%b", tag, k, obs, expOut[k]);
      end
      nCompared++;
      assert (cntObs === 8'(expCnt[k])) else begin
        nMismatched++;
        $error("[TB] FAIL %s dut%0d illegal_count observed=%0d expected=%0d", tag, k, cntObs, expCnt[k]);
      end
    end
  endtask

  // One clock of stimulus: drive, advance the model, sample after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic s,
                               input logic f, input logic v, input logic [5:0] op);
    reset    = r;
    stall    = s;
    flush    = f;
    valid_in = v;
    opcode   = op;
    modelStep(r, s, f, v, op);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [5:0] pickOpcode();
    case ($urandom_range(0, 9))
      0: return OP_RTYPE;
      1: return OP_LDB;
      2: return OP_LDW;
      3: return OP_STB;
      4: return OP_STW;
      5: return OP_BEQ;
      6: return OP_JUMP;
      7: return OP_MUL;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    for (int k = 0; k < 3; k++) begin
      remain[k] = 0;
      expCnt[k] = 0;
      expOut[k] = '0;
    end
    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; opcode = '0;

    applyStimulus("reset0", 1, 0, 0, 0, 6'h00);
    applyStimulus("reset1", 1, 0, 0, 0, 6'h00);
    applyStimulus("idle",   0, 0, 0, 0, 6'h00);

    applyStimulus("ldw",  0, 0, 0, 1, OP_LDW);
    applyStimulus("stb",  0, 0, 0, 1, OP_STB);
    applyStimulus("beq",  0, 0, 0, 1, OP_BEQ);
    applyStimulus("jump", 0, 0, 0, 1, OP_JUMP);
    applyStimulus("ldb",  0, 0, 0, 1, OP_LDB);
    applyStimulus("stw",  0, 0, 0, 1, OP_STW);

    applyStimulus("mul_accept", 0, 0, 0, 1, OP_MUL);
    for (int i = 0; i < 5; i++) applyStimulus("mul_wait", 0, 0, 0, 1, 6'h3F);

    applyStimulus("mulst_accept", 0, 0, 0, 1, OP_MUL);
    applyStimulus("mulst_c1",     0, 0, 0, 0, 6'h00);
    applyStimulus("mulst_stall",  0, 1, 0, 0, 6'h00);
    for (int i = 0; i < 4; i++) applyStimulus("mulst_wait", 0, 0, 0, 0, 6'h00);

    applyStimulus("mulfl_accept", 0, 0, 0, 1, OP_MUL);
    applyStimulus("mulfl_c1",     0, 0, 0, 0, 6'h00);
    applyStimulus("mulfl_flush",  0, 1, 1, 1, OP_RTYPE);
    applyStimulus("mulfl_rtype",  0, 0, 0, 1, OP_RTYPE);
    for (int i = 0; i < 3; i++) applyStimulus("mulfl_after", 0, 0, 0, 0, 6'h00);

    for (int i = 0; i < 5; i++) applyStimulus("illegal", 0, 0, 0, 1, 6'h3F);
    applyStimulus("illegal_novalid", 0, 0, 0, 0, 6'h3E);
    applyStimulus("illegal_stall",   0, 1, 0, 1, 6'h3D);

    applyStimulus("mulrst_accept", 0, 0, 0, 1, OP_MUL);
    applyStimulus("mulrst_reset",  1, 0, 0, 0, 6'h00);
    for (int i = 0; i < 4; i++) applyStimulus("mulrst_after", 0, 0, 0, 0, 6'h00);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0),
                    pickOpcode());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
